multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/ctrl_perf_cnt.sv | 23 ++
 rtl/multicycle_ctrl.sv | 131 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state encoding, opcode and alu_op constants for multicycle_ctrl
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/ctrl_perf_cnt.sv
// rtl/ctrl_perf_cnt.sv - wrapping cycle and retired-instruction counters
module ctrl_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cycle_en,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cycle_en) cycle_cnt <= cycle_cnt + 1'b1;
            if (retire)   instret_cnt <= instret_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle IF/ID/EX/MEM/WB control FSM; CTRL_PERF_CNT_EN adds perf counters
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [2:0]       state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t     state_q, state_d;
    logic [6:0] op_q;
    logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IF;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) op_q <= opcode;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        pc_src      = 1'b0;
        ir_write_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        alu_op      = ALU_ADD;
        case (state_q)
            S_IF: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    state_d    = S_ID;
                end
            end
            S_ID: state_d = op_supported(opcode) ? S_EX : S_TRAP;
            S_EX: begin
                case (op_q)
                    OP_R: begin
                        alu_op  = ALU_FUNCT;
                        state_d = S_WB;
                    end
                    OP_I: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_FUNCT;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op     = ALU_SUB;
                        pc_write_c = 1'b1;
                        pc_src     = zero;
                        state_d    = S_IF;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_read_c  = (op_q == OP_LW);
                mem_write_c = (op_q != OP_LW);
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        pc_write_c = 1'b1;
                        state_d    = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                mem_to_reg  = (op_q == OP_LW);
                state_d     = S_IF;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    assign pc_write  = pc_write_c  & rst;
    assign ir_write  = ir_write_c  & rst;
    assign mem_read  = mem_read_c  & rst;
    assign mem_write = mem_write_c & rst;
    assign reg_write = reg_write_c & rst;
    assign trap      = (state_q == S_TRAP);
    assign state     = state_q;

`ifdef CTRL_PERF_CNT_EN
    ctrl_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .cycle_en    (state_q != S_TRAP),
        .retire      (pc_write),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl (optionally with CTRL_PERF_CNT_EN)
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int TB_CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
    logic       mem_to_reg, alu_src, trap;
    logic [1:0] alu_op;
    logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [TB_CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [TB_CNT_W-1:0] m_cyc = '0;
    logic [TB_CNT_W-1:0] m_ret = '0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .trap       (trap),
        .state      (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    logic [13:0] obs;
    assign obs = {state, pc_write, pc_src, ir_write, mem_read, mem_write,
                  reg_write, mem_to_reg, alu_src, alu_op, trap};

    function automatic logic [13:0] ev(input state_t st, input logic pcw, input logic pcs,
                                       input logic irw, input logic mr, input logic mw,
                                       input logic rw, input logic m2r, input logic as,
                                       input logic [1:0] ao, input logic tr);
        return {st, pcw, pcs, irw, mr, mw, rw, m2r, as, ao, tr};
    endfunction

    task automatic step(input logic r, input logic [6:0] op_in, input logic rdy,
                        input logic z, input logic [13:0] exp, input string tag);
        @(negedge clk);
        rst = r; opcode = op_in; mem_ready = rdy; zero = z;
        #1;
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
`ifdef CTRL_PERF_CNT_EN
        n_cmp++;
        assert (cycle_cnt === m_cyc) else begin
            n_fail++;
            $error("FAIL %s cycle_cnt: observed=%0d expected=%0d", tag, cycle_cnt, m_cyc);
        end
        n_cmp++;
        assert (instret_cnt === m_ret) else begin
            n_fail++;
            $error("FAIL %s instret_cnt: observed=%0d expected=%0d", tag, instret_cnt, m_ret);
        end
`endif
        if (!r) begin
            m_cyc = '0;
            m_ret = '0;
        end else begin
            if (exp[13:11] != S_TRAP) m_cyc = m_cyc + 1'b1;
            if (exp[10]) m_ret = m_ret + 1'b1;
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic do_instr(input logic [6:0] op, input logic z, input int if_wait,
                            input int mem_wait, input bit abort_mem);
        bit is_lw  = (op == OP_LW);
        bit is_sw  = (op == OP_SW);
        bit is_beq = (op == OP_BEQ);
        bit is_i   = (op == OP_I);
        for (int i = 0; i < if_wait; i++)
            step(1, op, 0, rb(), ev(S_IF, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0), "if_wait");
        step(1, op, 1, rb(), ev(S_IF, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0), "if_fetch");
        step(1, op, rb(), rb(), ev(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "id");
        if (is_beq)
            step(1, 7'($urandom), rb(), z, ev(S_EX, 1, z, 0, 0, 0, 0, 0, 0, 2'b01, 0), "ex_beq");
        else if (is_lw || is_sw)
            step(1, 7'($urandom), rb(), rb(), ev(S_EX, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0), "ex_mem");
        else
            step(1, 7'($urandom), rb(), rb(), ev(S_EX, 0, 0, 0, 0, 0, 0, 0, is_i, 2'b10, 0), "ex_alu");
        if (is_lw || is_sw) begin
            if (abort_mem) begin
                step(0, 7'($urandom), 0, rb(), ev(S_MEM, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "mem_abort");
                return;
            end
            for (int i = 0; i < mem_wait; i++)
                step(1, 7'($urandom), 0, rb(), ev(S_MEM, 0, 0, 0, is_lw, is_sw, 0, 0, 0, 2'b00, 0), "mem_wait");
            step(1, 7'($urandom), 1, rb(), ev(S_MEM, is_sw, 0, 0, is_lw, is_sw, 0, 0, 0, 2'b00, 0), "mem_done");
        end
        if (!is_beq && !is_sw)
            step(1, 7'($urandom), rb(), rb(), ev(S_WB, 1, 0, 0, 0, 0, 1, is_lw, 0, 2'b00, 0), "wb");
    endtask

    logic [6:0] ops [5];

    initial begin
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};

        step(0, '0, 1, 0, ev(S_IF, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "reset_0");
        step(0, '0, 1, 0, ev(S_IF, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "reset_1");

        do_instr(OP_R, 0, 0, 0, 0);
        do_instr(OP_LW, 0, 0, 2, 0);
        do_instr(OP_BEQ, 1, 0, 0, 0);
        do_instr(OP_BEQ, 0, 0, 0, 0);
        do_instr(OP_SW, 0, 1, 1, 0);
        do_instr(OP_I, 0, 2, 0, 0);

        for (int n = 0; n < 30; n++)
            do_instr(ops[$urandom_range(0, 4)], rb(), $urandom_range(0, 2), $urandom_range(0, 2), 0);

        do_instr(OP_SW, 0, 0, 0, 1);
        step(1, '0, 0, 0, ev(S_IF, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0), "after_abort");
        do_instr(OP_LW, 0, 0, 0, 1);
        step(1, '0, 1, 0, ev(S_IF, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0), "after_abort_lw");
        step(1, OP_R, 1, 0, ev(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "id_r");
        step(1, '0, 1, 0, ev(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0), "ex_r");
        step(1, '0, 1, 0, ev(S_WB, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0), "wb_r");

        step(1, 7'h7f, 1, 0, ev(S_IF, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0), "trap_if");
        step(1, 7'h7f, rb(), 0, ev(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "trap_id");
        for (int i = 0; i < 10; i++)
            step(1, 7'($urandom), rb(), rb(), ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1), "trap_hold");
        step(0, '0, 1, 0, ev(S_TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1), "trap_rst");
        step(1, '0, 0, 0, ev(S_IF, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0), "trap_exit");

        step(0, '0, 0, 0, ev(S_IF, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "reset_cnt");
        for (int n = 0; n < 20; n++)
            do_instr(OP_R, 0, 0, 0, 0);
        step(1, '0, 0, 0, ev(S_IF, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0), "final_if");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
